// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed RX bit recovery: mid-bit sampling, NRZI decode, bit unstuffing, SE0 EOP detect.
// Define USB_RX_STUFF_CHECK_EN to treat a decoded 1 after six consecutive 1s as a stuff error.
module usb_rx_bit_decoder #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic d_plus_sync,
   input  logic d_minus_sync,
   output logic bit_valid,
   output logic bit_out,
   output logic eop,
   output logic rx_err,
   output logic rx_active
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);

   logic          dp_q;
   logic          prev_level;
   logic [CW-1:0] cnt;
   logic [2:0]    ones_cnt;
   logic [1:0]    se0_cnt;

   logic edge_det;
   logic sample;
   logic se0;
   logic decoded;
   logic eop_now;
   logic err_now;
   logic emit;
   logic stop;

   assign edge_det = dp_q ^ d_plus_sync;
   assign sample   = (cnt == CNT_MID);
   assign se0      = ~d_plus_sync & ~d_minus_sync;
   // (1,1) reads as J because only D+ selects the level
   assign decoded  = (d_plus_sync == prev_level);

   always_comb begin
      eop_now = 1'b0;
      err_now = 1'b0;
      emit    = 1'b0;
      if (rx_active && sample && !se0) begin
         if (se0_cnt != 2'd0) begin
            eop_now = d_plus_sync && (se0_cnt >= 2'd2);
            err_now = !eop_now;
         end else if (ones_cnt != 3'd6) begin
            emit = 1'b1;
         end
`ifdef USB_RX_STUFF_CHECK_EN
         else begin
            err_now = decoded;
         end
`endif
      end
   end

   assign stop = eop_now | err_now;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_q       <= 1'b1;
         prev_level <= 1'b1;
         cnt        <= '0;
         ones_cnt   <= '0;
         se0_cnt    <= '0;
         bit_valid  <= 1'b0;
         bit_out    <= 1'b0;
         eop        <= 1'b0;
         rx_err     <= 1'b0;
         rx_active  <= 1'b0;
      end else begin
         dp_q      <= d_plus_sync;
         bit_valid <= emit;
         eop       <= eop_now;
         rx_err    <= err_now;
         if (emit) begin
            bit_out <= decoded;
         end

         if (stop) begin
            rx_active  <= 1'b0;
            prev_level <= 1'b1;
            ones_cnt   <= '0;
            se0_cnt    <= '0;
            cnt        <= '0;
         end else begin
            if (edge_det) begin
               cnt <= CW'(1);
            end else if (cnt == CNT_LAST) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end

            if (!rx_active && edge_det && !d_plus_sync) begin
               rx_active <= 1'b1;
            end

            if (rx_active && sample) begin
               if (se0) begin
                  if (se0_cnt != 2'd3) begin
                     se0_cnt <= se0_cnt + 2'd1;
                  end
               end else begin
                  prev_level <= d_plus_sync;
                  se0_cnt    <= '0;
                  // a stuffed bit or an unchecked overlong run restarts the count
                  ones_cnt   <= (decoded && ones_cnt != 3'd6) ? ones_cnt + 3'd1 : 3'd0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Directed bench for usb_rx_bit_decoder: SYNC, unstuffing, stuff error, EOP variants, jitter, reset.
module tb_usb_rx_bit_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic dp  = 1'b1;
   logic dm  = 1'b0;
   logic bit_valid, bit_out, eop, rx_err, rx_active;

   int   cyc      = 0;
   int   total    = 0;
   int   passed   = 0;
   int   fails    = 0;
   int   eop_n    = 0;
   int   err_n    = 0;
   int   multi_n  = 0;
   int   first_bv = -1;
   int   t0       = 0;
   logic lvl      = 1'b1;
   logic bq[$];

   usb_rx_bit_decoder #(.CLKS_PER_BIT(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .d_plus_sync  (dp),
      .d_minus_sync (dm),
      .bit_valid    (bit_valid),
      .bit_out      (bit_out),
      .eop          (eop),
      .rx_err       (rx_err),
      .rx_active    (rx_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bit_valid) begin
         bq.push_back(bit_out);
         if (first_bv < 0) first_bv = cyc;
      end
      if (eop) eop_n++;
      if (rx_err) err_n++;
      if (int'(bit_valid) + int'(eop) + int'(rx_err) > 1) multi_n++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic p, input logic m, input int n);
      dp = p;
      dm = m;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic nrzi(input logic b, input int n);
      if (!b) lvl = ~lvl;
      hold(lvl, ~lvl, n);
   endtask

   task automatic sync_pkt();
      for (int i = 0; i < 8; i++) nrzi(i == 7, 8);
   endtask

   task automatic eop_seq(input int n_se0);
      hold(1'b0, 1'b0, n_se0);
      lvl = 1'b1;
      hold(1'b1, 1'b0, 24);
   endtask

   task automatic clear();
      bq.delete();
      eop_n    = 0;
      err_n    = 0;
      first_bv = -1;
   endtask

   function automatic int packq();
      int v = 0;
      foreach (bq[i]) v = (v << 1) | int'(bq[i]);
      return v;
   endfunction

   initial begin
      #1;
      chk("rst_bit_valid", int'(bit_valid), 0);
      chk("rst_bit_out", int'(bit_out), 0);
      chk("rst_eop", int'(eop), 0);
      chk("rst_rx_err", int'(rx_err), 0);
      chk("rst_rx_active", int'(rx_active), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      clear();
      hold(1'b1, 1'b0, 40);
      chk("idle_bits", bq.size(), 0);
      chk("idle_active", int'(rx_active), 0);

      // SYNC: KJKJKJKK decodes to 0000_0001
      clear();
      t0 = cyc;
      sync_pkt();
      chk("sync_latency", first_bv - t0, 5);
      chk("sync_count", bq.size(), 8);
      chk("sync_bits", packq(), 'h01);
      chk("sync_active", int'(rx_active), 1);

      // SYNC's trailing 1 plus five data 1s reach six, so the next 0 is stuffed
      clear();
      for (int i = 0; i < 5; i++) nrzi(1'b1, 8);
      nrzi(1'b0, 8);
      nrzi(1'b1, 8);
      nrzi(1'b0, 8);
      chk("unstuff_count", bq.size(), 7);
      chk("unstuff_bits", packq(), 'h7E);
      chk("unstuff_active", int'(rx_active), 1);

      clear();
      eop_seq(16);
      chk("eop_bits", bq.size(), 0);
      chk("eop_pulse", eop_n, 1);
      chk("eop_err", err_n, 0);
      chk("eop_active", int'(rx_active), 0);

      // seven NRZI 1s after SYNC
      clear();
      sync_pkt();
      clear();
      for (int i = 0; i < 7; i++) nrzi(1'b1, 8);
`ifdef USB_RX_STUFF_CHECK_EN
      chk("stufferr_count", bq.size(), 5);
      chk("stufferr_bits", packq(), 'h1F);
      chk("stufferr_err", err_n, 1);
      chk("stufferr_active", int'(rx_active), 0);
      eop_seq(16);
      chk("stufferr_eop", eop_n, 0);
`else
      chk("stufferr_count", bq.size(), 6);
      chk("stufferr_bits", packq(), 'h3F);
      chk("stufferr_err", err_n, 0);
      chk("stufferr_active", int'(rx_active), 1);
      eop_seq(16);
      chk("stufferr_eop", eop_n, 1);
`endif
      chk("stufferr_end_active", int'(rx_active), 0);

      // one-sample SE0 is a malformed EOP
      clear();
      sync_pkt();
      clear();
      eop_seq(8);
      chk("short_eop_err", err_n, 1);
      chk("short_eop_eop", eop_n, 0);
      chk("short_eop_bits", bq.size(), 0);
      chk("short_eop_active", int'(rx_active), 0);

      // SYNC with one cell stretched to 9 and the next shrunk to 7
      clear();
      t0 = cyc;
      for (int i = 0; i < 8; i++) nrzi(i == 7, (i == 3) ? 9 : ((i == 4) ? 7 : 8));
      chk("jitter_latency", first_bv - t0, 5);
      chk("jitter_count", bq.size(), 8);
      chk("jitter_bits", packq(), 'h01);
      clear();
      eop_seq(16);
      chk("jitter_eop", eop_n, 1);
      chk("jitter_err", err_n, 0);

      // async reset in the middle of a K run
      clear();
      sync_pkt();
      nrzi(1'b1, 8);
      nrzi(1'b1, 8);
      chk("prerst_active", int'(rx_active), 1);
      chk("prerst_bit_out", int'(bit_out), 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_active", int'(rx_active), 0);
      chk("midrst_bit_out", int'(bit_out), 0);
      chk("midrst_bit_valid", int'(bit_valid), 0);
      chk("midrst_eop", int'(eop), 0);
      chk("midrst_rx_err", int'(rx_err), 0);
      lvl = 1'b1;
      dp  = 1'b1;
      dm  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear();
      hold(1'b1, 1'b0, 40);
      chk("postrst_bits", bq.size(), 0);
      chk("postrst_active", int'(rx_active), 0);
      chk("postrst_eop", eop_n, 0);
      chk("postrst_err", err_n, 0);

      chk("exclusive_pulses", multi_n, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
